led_matrix_scanner: RTL and testbench
=====================================

# led_matrix_scanner

Receiving end of the time-multiplexed pixel-word stream emitted by the game logic on its 10-bit LED bus. Each word names one lit dot and its colour. The block collects these words over one frame window into a capture bank and swaps it into a display bank at the window end. It then scans the display bank onto the physical 16-row × 8-column bi-colour dot matrix, one row at a time, inserting blanking between rows to suppress ghosting.

## Interface
- FRAME_LEN, 256128: clocks per capture window; this is one full 128-slot pixel-word cycle at a 2001-clock slot period.
- ROW_DWELL, 2000: clocks each row is driven.
- BLANK_LEN, 16: clocks of all-off between rows; must be ≥1.
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- PIXIN  in  10  pixel word:
  - [9] red
  - [8] green
  - [7] ignored
  - [6:3] row 0–15
  - [2:0] column 0–7
  - [9:8]==00 means idle.
- ROW_SEL  out  16  one-hot row drive, active-high; bit n = row n.
- COL_R  out  8  red column drive, bit x = column x.
- COL_G  out  8  green column drive.
- FRAME_DONE  out  1  one-clock pulse on each bank swap.

## Operation
**Storage**
- Two banks, capture and display, each 16×8×2 bits.

**Capture**
- PIXIN is sampled every clock.
- If [9] is set, capture red bit [row][col] is set; if [8] is set, capture green bit [row][col] is set.
- Bits are only ever set, never cleared, within a window.
- Duplicate words are harmless.

**Frame counter**
- Counts 0..FRAME_LEN-1 and wraps.
- On the cycle where the count equals FRAME_LEN-1:
  - The display bank is loaded with the capture bank contents, including any word arriving that same cycle.
  - The capture bank is cleared.
  - FRAME_DONE is asserted on the next cycle.

**Scan FSM**
- States: BLANK, DRIVE.
- BLANK:
  - ROW_SEL, COL_R and COL_G are all 0.
  - Lasts BLANK_LEN clocks.
  - On exit, the row pointer advances (15→0 wraps), that row's red and green bytes are latched from the display bank, and the FSM enters DRIVE.
- DRIVE:
  - ROW_SEL = 1<<row; COL_R and COL_G are the latched bytes.
  - Lasts ROW_DWELL clocks, then returns to BLANK.

**Boundary rules**
- A bank swap during DRIVE does not alter the current row; the new data appears from the next row onward (no intra-row tearing).
- A swap during BLANK takes effect on the row latched at BLANK exit.

**Reset**
- Any time RST is high, immediately:
  - Both banks are cleared.
  - Frame counter = 0.
  - FSM = BLANK with dwell counter 0.
  - Row pointer = 15, so the first driven row is 0.
  - ROW_SEL = 0, COL_R = 0, COL_G = 0, FRAME_DONE = 0.
- Reset mid-row or mid-window discards all state.

## Timing
- PIXIN to capture bank: 1 clock.
- Capture to visible: at the window end plus up to one full row period.
- Row period is BLANK_LEN+ROW_DWELL clocks; a full refresh is 16× that (32256 clocks at defaults).
- All outputs are registered.
- ROW_SEL is never multi-hot, and never non-zero while the column drives are in transition.
- First DRIVE after reset release: row 0, beginning BLANK_LEN clocks after the first clock edge with RST low.
- FRAME_DONE first pulses FRAME_LEN clocks after reset release.
- Counter widths: ceil(log2) of each parameter, with no overflow at the maximum value.

## Structure
**Shared package led_matrix_pkg**
- ROWS=16, COLS=8.
- PIXIN field positions: RED_BIT=9, GRN_BIT=8, ROW_MSB/LSB=6/3, COL_MSB/LSB=2/0.
- Scan state enum {BLANK, DRIVE}.

**Sub-module led_frame_buffer**
- Holds both banks.
- Write port: row, col, red, grn.
- Swap/clear strobe.
- Combinational row-read port returning {red byte, green byte}.

**Top level**
- Holds the frame counter, the scan FSM and the output registers.

## Test plan
- Reset: hold RST high, drive PIXIN random → ROW_SEL=0, COL_R=0, COL_G=0, FRAME_DONE=0 throughout; after release, run with FRAME_LEN=64, ROW_DWELL=8, BLANK_LEN=2 → first DRIVE row 0 with zero columns.
- Capture/swap: with FRAME_LEN=64, drive words 0x268 (red, row 13, col 0) and 0x11B (green, row 3, col 3) in window 0 → after FRAME_DONE, row 13 shows COL_R=0x01, COL_G=0x00 and row 3 shows COL_R=0x00, COL_G=0x08; the next window with idle input shows all zeros.
- Both colours: word 0x3FF → row 15 COL_R=0x80, COL_G=0x80; words with [9:8]=00 never set any bit.
- Scan cadence: count 10 clocks per row (8 drive + 2 blank), rows 0..15 then 0, ROW_SEL always one-hot or zero, zero during blank.
- Swap mid-row: swap occurs on DRIVE cycle 4 of row 5 with changed data → row 5 columns stay constant for all 8 cycles; row 6 shows new data.
- Reset mid-operation: assert RST during DRIVE of row 9 with captured data → outputs 0 on the same cycle; after release the display is empty and the scan restarts at row 0.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared constants, field positions and types for the LED matrix scanner.
package led_matrix_pkg;

  localparam int unsigned ROWS    = 16;
  localparam int unsigned COLS    = 8;

  localparam int unsigned RED_BIT = 9;
  localparam int unsigned GRN_BIT = 8;
  localparam int unsigned ROW_MSB = 6;
  localparam int unsigned ROW_LSB = 3;
  localparam int unsigned COL_MSB = 2;
  localparam int unsigned COL_LSB = 0;

  localparam int unsigned ROW_W   = ROW_MSB - ROW_LSB + 1;
  localparam int unsigned COL_W   = COL_MSB - COL_LSB + 1;

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [COL_W-1:0] col_t;
  typedef logic [COLS-1:0]  col_bits_t;

  typedef enum logic {BLANK, DRIVE} scan_state_e;

  function automatic logic [ROWS-1:0] row_onehot(input row_t r);
    logic [ROWS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Capture and display banks; capture bits are set-only and move to the
// display bank (including a same-cycle write) on the swap strobe.
module led_frame_buffer
  import led_matrix_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  row_t            wr_row,
  input  col_t            wr_col,
  input  logic            wr_red,
  input  logic            wr_grn,
  input  logic            swap,
  input  row_t            rd_row,
  output logic [2*COLS-1:0] rd_data
);

  logic [ROWS-1:0][COLS-1:0] cap_r_q, cap_g_q;
  logic [ROWS-1:0][COLS-1:0] dis_r_q, dis_g_q;
  logic [ROWS-1:0][COLS-1:0] cap_r_set, cap_g_set;

  always_comb begin
    cap_r_set = cap_r_q;
    cap_g_set = cap_g_q;
    if (wr_red) cap_r_set[wr_row][wr_col] = 1'b1;
    if (wr_grn) cap_g_set[wr_row][wr_col] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_r_q <= '0;
      cap_g_q <= '0;
      dis_r_q <= '0;
      dis_g_q <= '0;
    end else if (swap) begin
      dis_r_q <= cap_r_set;
      dis_g_q <= cap_g_set;
      cap_r_q <= '0;
      cap_g_q <= '0;
    end else begin
      cap_r_q <= cap_r_set;
      cap_g_q <= cap_g_set;
    end
  end

  assign rd_data = {dis_r_q[rd_row], dis_g_q[rd_row]};

endmodule

// File: rtl/led_matrix_scanner.sv
// Collects pixel words per frame window and scans the displayed frame onto a
// 16x8 bi-colour matrix one row at a time with blanking between rows.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 256128,
  parameter int unsigned ROW_DWELL = 2000,
  parameter int unsigned BLANK_LEN = 16
)(
  input  logic            CLK,
  input  logic            RST,
  input  logic [9:0]      PIXIN,
  output logic [ROWS-1:0] ROW_SEL,
  output logic [COLS-1:0] COL_R,
  output logic [COLS-1:0] COL_G,
  output logic            FRAME_DONE
);

  localparam int unsigned FC_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned DWELL_MAX = (ROW_DWELL > BLANK_LEN) ? ROW_DWELL : BLANK_LEN;
  localparam int unsigned DW_W      = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAME_LEN - 1);
  localparam logic [DW_W-1:0] BLANK_LAST = DW_W'(BLANK_LEN - 1);
  localparam logic [DW_W-1:0] DRIVE_LAST = DW_W'(ROW_DWELL - 1);

  logic [FC_W-1:0] frame_q;
  logic            swap;
  logic            frame_done_q;
  logic            pix_unused;

  scan_state_e     state_q, state_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  row_t            row_q, row_d, next_row;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  col_bits_t       col_r_q, col_r_d, col_g_q, col_g_d;
  logic [2*COLS-1:0] rd_data;

  assign pix_unused = PIXIN[7];
  assign swap       = (frame_q == FRAME_LAST);
  assign next_row   = row_q + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_q      <= swap ? '0 : frame_q + 1'b1;
      frame_done_q <= swap;
    end
  end

  led_frame_buffer u_fb (
    .CLK     (CLK),
    .RST     (RST),
    .wr_row  (PIXIN[ROW_MSB:ROW_LSB]),
    .wr_col  (PIXIN[COL_MSB:COL_LSB]),
    .wr_red  (PIXIN[RED_BIT]),
    .wr_grn  (PIXIN[GRN_BIT]),
    .swap    (swap),
    .rd_row  (next_row),
    .rd_data (rd_data)
  );

  // Column bytes are latched only at BLANK exit, so a bank swap mid-row
  // cannot tear the row being driven.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q + 1'b1;
    row_d     = row_q;
    row_sel_d = row_sel_q;
    col_r_d   = col_r_q;
    col_g_d   = col_g_q;
    case (state_q)
      BLANK: begin
        row_sel_d = '0;
        col_r_d   = '0;
        col_g_d   = '0;
        if (dwell_q == BLANK_LAST) begin
          state_d   = DRIVE;
          dwell_d   = '0;
          row_d     = next_row;
          row_sel_d = row_onehot(next_row);
          col_r_d   = rd_data[2*COLS-1:COLS];
          col_g_d   = rd_data[COLS-1:0];
        end
      end
      DRIVE: begin
        if (dwell_q == DRIVE_LAST) begin
          state_d   = BLANK;
          dwell_d   = '0;
          row_sel_d = '0;
          col_r_d   = '0;
          col_g_d   = '0;
        end
      end
      default: begin
        state_d = BLANK;
        dwell_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= BLANK;
      dwell_q   <= '0;
      row_q     <= '1;
      row_sel_q <= '0;
      col_r_q   <= '0;
      col_g_q   <= '0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      row_q     <= row_d;
      row_sel_q <= row_sel_d;
      col_r_q   <= col_r_d;
      col_g_q   <= col_g_d;
    end
  end

  assign ROW_SEL    = row_sel_q;
  assign COL_R      = col_r_q;
  assign COL_G      = col_g_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomised and directed bench for led_matrix_scanner against a frame/scan
// model derived from edge counts since reset release.
module tb_led_matrix_scanner;

  localparam int FL  = 64;
  localparam int RD  = 8;
  localparam int BL  = 2;
  localparam int RP  = RD + BL;
  localparam int FL2 = 55;

  logic        CLK;
  logic        RST;
  logic [9:0]  PIXIN;
  logic [15:0] ROW_SEL, row_sel2;
  logic [7:0]  COL_R, COL_G, col_r2, col_g2;
  logic        FRAME_DONE, frame_done2;
  logic [32:0] dut_vec, dut2_vec;

  int checks   = 0;
  int failures = 0;

  int        n;
  int        mrow;
  logic [7:0] mcap_r [16];
  logic [7:0] mcap_g [16];
  logic [7:0] mdis_r [16];
  logic [7:0] mdis_g [16];
  logic [7:0] mlat_r, mlat_g;

  led_matrix_scanner #(.FRAME_LEN(FL), .ROW_DWELL(RD), .BLANK_LEN(BL)) dut (
    .CLK(CLK), .RST(RST), .PIXIN(PIXIN), .ROW_SEL(ROW_SEL),
    .COL_R(COL_R), .COL_G(COL_G), .FRAME_DONE(FRAME_DONE)
  );

  // Second instance whose window ends mid-way through the drive of row 5.
  led_matrix_scanner #(.FRAME_LEN(FL2), .ROW_DWELL(RD), .BLANK_LEN(BL)) dut2 (
    .CLK(CLK), .RST(RST), .PIXIN(PIXIN), .ROW_SEL(row_sel2),
    .COL_R(col_r2), .COL_G(col_g2), .FRAME_DONE(frame_done2)
  );

  assign dut_vec  = {ROW_SEL, COL_R, COL_G, FRAME_DONE};
  assign dut2_vec = {row_sel2, col_r2, col_g2, frame_done2};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    n = 0; mrow = 0; mlat_r = '0; mlat_g = '0;
    for (int r = 0; r < 16; r++) begin
      mcap_r[r] = '0; mcap_g[r] = '0; mdis_r[r] = '0; mdis_g[r] = '0;
    end
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    repeat (3) begin
      PIXIN = 10'($urandom);
      @(posedge CLK);
    end
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  // One clock with word w sampled; model follows the edge, then sample point.
  task automatic tick(input logic [9:0] w);
    PIXIN = w;
    @(posedge CLK);
    n++;
    if (n % RP == BL) begin
      mrow   = (n / RP) % 16;
      mlat_r = mdis_r[mrow];
      mlat_g = mdis_g[mrow];
    end
    if (w[9]) mcap_r[w[6:3]][w[2:0]] = 1'b1;
    if (w[8]) mcap_g[w[6:3]][w[2:0]] = 1'b1;
    if (n % FL == 0) begin
      for (int r = 0; r < 16; r++) begin
        mdis_r[r] = mcap_r[r]; mdis_g[r] = mcap_g[r];
        mcap_r[r] = '0;        mcap_g[r] = '0;
      end
    end
    #1;
  endtask

  function automatic logic [32:0] exp_vec();
    logic        drive;
    logic [15:0] rs;
    drive = (n % RP) >= BL;
    rs    = drive ? (16'd1 << mrow) : 16'd0;
    return {rs, drive ? mlat_r : 8'h00, drive ? mlat_g : 8'h00,
            (n > 0) && (n % FL == 0)};
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 16; i++) begin
      PIXIN = 10'($urandom);
      @(posedge CLK); #1;
      checks++;
      if ({dut_vec, dut2_vec} !== 66'd0)
        begin failures++; $display("FAIL reset_hold got=%h/%h exp=0", dut_vec, dut2_vec); end
    end
    RST = 1'b0;
    model_reset();
    checks++;
    if (dut_vec !== 33'd0)
      begin failures++; $display("FAIL reset_release got=%h exp=0", dut_vec); end
    for (int i = 0; i < 12; i++) begin
      tick(10'h000);
      checks++;
      if (dut_vec !== exp_vec())
        begin failures++; $display("FAIL reset_scan n=%0d got=%h exp=%h", n, dut_vec, exp_vec()); end
      if (n == BL) begin
        checks++;
        if ({ROW_SEL, COL_R, COL_G} !== {16'h0001, 16'h0000})
          begin failures++; $display("FAIL first_drive got=%h exp=%h", {ROW_SEL, COL_R, COL_G}, {16'h0001, 16'h0000}); end
      end
    end
  endtask

  task automatic test_capture_swap();
    logic [9:0] w;
    apply_reset();
    for (int i = 0; i < 360; i++) begin
      w = (n < 192) ? ((n % 2 == 0) ? 10'h268 : 10'h11B) : 10'h000;
      tick(w);
      checks++;
      if (dut_vec !== exp_vec())
        begin failures++; $display("FAIL capture n=%0d got=%h exp=%h", n, dut_vec, exp_vec()); end
      if (n == 133 || n == 193 || n == 293 || n == 353) begin
        checks++;
        case (n)
          133: if ({ROW_SEL, COL_R, COL_G} !== {16'h2000, 8'h01, 8'h00})
                 begin failures++; $display("FAIL row13_red got=%h exp=%h", {ROW_SEL, COL_R, COL_G}, {16'h2000, 8'h01, 8'h00}); end
          193: if ({ROW_SEL, COL_R, COL_G} !== {16'h0008, 8'h00, 8'h08})
                 begin failures++; $display("FAIL row3_green got=%h exp=%h", {ROW_SEL, COL_R, COL_G}, {16'h0008, 8'h00, 8'h08}); end
          293: if ({ROW_SEL, COL_R, COL_G} !== {16'h2000, 8'h00, 8'h00})
                 begin failures++; $display("FAIL row13_cleared got=%h exp=%h", {ROW_SEL, COL_R, COL_G}, {16'h2000, 8'h00, 8'h00}); end
          default: if ({ROW_SEL, COL_R, COL_G} !== {16'h0008, 8'h00, 8'h00})
                 begin failures++; $display("FAIL row3_cleared got=%h exp=%h", {ROW_SEL, COL_R, COL_G}, {16'h0008, 8'h00, 8'h00}); end
        endcase
      end
    end
  endtask

  task automatic test_both_colours();
    logic [9:0] w;
    apply_reset();
    for (int i = 0; i < 170; i++) begin
      w = 10'($urandom);
      w[9:8] = 2'b00;
      if (n < 128 && (n % 3 == 0)) w = 10'h3FF;
      tick(w);
      checks++;
      if (dut_vec !== exp_vec())
        begin failures++; $display("FAIL both_colours n=%0d got=%h exp=%h", n, dut_vec, exp_vec()); end
      if (n == 155) begin
        checks++;
        if ({ROW_SEL, COL_R, COL_G} !== {16'h8000, 8'h80, 8'h80})
          begin failures++; $display("FAIL row15_both got=%h exp=%h", {ROW_SEL, COL_R, COL_G}, {16'h8000, 8'h80, 8'h80}); end
      end
      if (n == 105) begin
        checks++;
        if ({ROW_SEL, COL_R, COL_G} !== {16'h0400, 8'h00, 8'h00})
          begin failures++; $display("FAIL idle_words got=%h exp=%h", {ROW_SEL, COL_R, COL_G}, {16'h0400, 8'h00, 8'h00}); end
      end
    end
  endtask

  task automatic test_random_stream();
    logic [9:0] w;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      w = 10'($urandom);
      if ($urandom_range(0, 4) < 3) w[9:8] = 2'b00;
      tick(w);
      checks++;
      if (dut_vec !== exp_vec())
        begin failures++; $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_scan_cadence();
    int last_rise, prev_row, rise_row, drive_len, rises;
    logic [15:0] prev;
    apply_reset();
    last_rise = -1; prev_row = 15; rise_row = 0; drive_len = 0; rises = 0; prev = '0;
    for (int i = 0; i < 180; i++) begin
      tick(10'h000);
      checks++;
      if ($countones(ROW_SEL) > 1)
        begin failures++; $display("FAIL onehot n=%0d got=%h exp=onehot", n, ROW_SEL); end
      if (ROW_SEL == 16'h0) begin
        checks++;
        if ({COL_R, COL_G} !== 16'h0)
          begin failures++; $display("FAIL blank_cols n=%0d got=%h exp=0", n, {COL_R, COL_G}); end
      end
      if (ROW_SEL != 16'h0 && prev == 16'h0) begin
        for (int b = 0; b < 16; b++) if (ROW_SEL[b]) rise_row = b;
        rises++;
        checks++;
        if (rise_row != (prev_row + 1) % 16)
          begin failures++; $display("FAIL row_order n=%0d got=%0d exp=%0d", n, rise_row, (prev_row + 1) % 16); end
        checks++;
        if ((last_rise < 0) ? (n != BL) : (n - last_rise != RP))
          begin failures++; $display("FAIL row_period n=%0d got=%0d exp=%0d", n, n - last_rise, RP); end
        last_rise = n; prev_row = rise_row; drive_len = 0;
      end
      if (ROW_SEL != 16'h0) drive_len++;
      if (ROW_SEL == 16'h0 && prev != 16'h0) begin
        checks++;
        if (drive_len != RD)
          begin failures++; $display("FAIL drive_len n=%0d got=%0d exp=%0d", n, drive_len, RD); end
      end
      prev = ROW_SEL;
    end
    checks++;
    if (rises != 18)
      begin failures++; $display("FAIL rise_count got=%0d exp=18", rises); end
  endtask

  task automatic test_swap_mid_row();
    logic [9:0] w;
    apply_reset();
    for (int i = 0; i < 70; i++) begin
      w = (n < FL2) ? ((n % 2 == 0) ? 10'h22A : 10'h137) : 10'h000;
      tick(w);
      checks++;
      if (dut_vec !== exp_vec())
        begin failures++; $display("FAIL swap_main n=%0d got=%h exp=%h", n, dut_vec, exp_vec()); end
      if (n >= 52 && n <= 59) begin
        checks++;
        if ({row_sel2, col_r2, col_g2} !== {16'h0020, 8'h00, 8'h00})
          begin failures++; $display("FAIL row5_no_tear n=%0d got=%h exp=%h", n, {row_sel2, col_r2, col_g2}, {16'h0020, 8'h00, 8'h00}); end
      end
      if (n == FL2 || n == FL2 + 1) begin
        checks++;
        if (frame_done2 !== (n == FL2))
          begin failures++; $display("FAIL frame_done2 n=%0d got=%b exp=%b", n, frame_done2, n == FL2); end
      end
      if (n >= 62 && n <= 69) begin
        checks++;
        if ({row_sel2, col_r2, col_g2} !== {16'h0040, 8'h00, 8'h80})
          begin failures++; $display("FAIL row6_new n=%0d got=%h exp=%h", n, {row_sel2, col_r2, col_g2}, {16'h0040, 8'h00, 8'h80}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] w;
    apply_reset();
    for (int i = 0; i < 95; i++) begin
      w = (n < FL) ? ((n % 2 == 0) ? 10'h24D : 10'h111) : 10'h000;
      tick(w);
      checks++;
      if (dut_vec !== exp_vec())
        begin failures++; $display("FAIL pre_reset n=%0d got=%h exp=%h", n, dut_vec, exp_vec()); end
    end
    checks++;
    if ({ROW_SEL, COL_R, COL_G} !== {16'h0200, 8'h20, 8'h00})
      begin failures++; $display("FAIL row9_before got=%h exp=%h", {ROW_SEL, COL_R, COL_G}, {16'h0200, 8'h20, 8'h00}); end
    RST = 1'b1;
    #1;
    checks++;
    if ({dut_vec, dut2_vec} !== 66'd0)
      begin failures++; $display("FAIL async_reset got=%h/%h exp=0", dut_vec, dut2_vec); end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 190; i++) begin
      tick(10'h000);
      checks++;
      if (dut_vec !== exp_vec())
        begin failures++; $display("FAIL post_reset n=%0d got=%h exp=%h", n, dut_vec, exp_vec()); end
      if (n == BL || n == 22 || n == 92) begin
        checks++;
        if ({ROW_SEL, COL_R, COL_G} !== {16'd1 << ((n / RP) % 16), 16'h0000})
          begin failures++; $display("FAIL restart n=%0d got=%h exp=%h", n, {ROW_SEL, COL_R, COL_G}, {16'd1 << ((n / RP) % 16), 16'h0000}); end
      end
    end
  endtask

  initial begin
    RST   = 1'b1;
    PIXIN = '0;
    model_reset();
    test_reset();
    test_capture_swap();
    test_both_colours();
    test_random_stream();
    test_scan_cadence();
    test_swap_mid_row();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
